// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared address-width, reset-vector and address type definitions
//            for the single-cycle CPU datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int          ADDR_W       = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_3000;
  localparam int          INSTR_BYTES  = 4;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// Module   : program_counter
// Purpose  : Fetch-address register loaded from NPC every cycle, with an
//            inline PC+4 and an optional sticky misalignment flag.
//            Build option: define PC_ALIGN_CHECK_EN to enable MISALIGN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR
) (
  output logic [WIDTH-1:0] PC,
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] NPC,
  output logic [WIDTH-1:0] PC_PLUS4,
  output logic             MISALIGN
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // No enable or stall path: the next-PC value is always taken as-is.
  always_comb begin
    pc_d = NPC;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC       = pc_q;
  assign PC_PLUS4 = pc_q + WIDTH'(INSTR_BYTES);

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (NPC[1:0] != 2'b00) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign MISALIGN = misalign_q;

`ifndef SYNTHESIS
  always @(posedge CLOCK) begin
    if (!RESET && (NPC[1:0] != 2'b00)) begin
      $display("ERROR %0t: misaligned NPC load 0x%h (previous PC 0x%h)",
               $time, NPC, pc_q);
    end
  end
`endif
`else
  assign MISALIGN = 1'b0;
`endif

endmodule : program_counter

`default_nettype wire

// File: tb/tb_program_counter.sv
// ============================================================================
// Module   : tb_program_counter
// Purpose  : Directed self-checking bench for program_counter; expected
//            MISALIGN follows the PC_ALIGN_CHECK_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_counter;

  logic        clk;
  logic        rst;
  logic [31:0] w_npc;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic        w_misalign;

  int r_checks = 0;
  int r_passed = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic c_ALIGN_EN = 1'b1;
`else
  localparam logic c_ALIGN_EN = 1'b0;
`endif

  program_counter #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_3000)
  ) u_dut (
    .PC       (w_pc),
    .CLOCK    (clk),
    .RESET    (rst),
    .NPC      (w_npc),
    .PC_PLUS4 (w_pc_plus4),
    .MISALIGN (w_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    r_checks++;
    if (obs === exp) begin
      r_passed++;
    end else begin
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    w_npc = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc",       w_pc,       32'h0000_3000);
    check("reset_pc_plus4", w_pc_plus4, 32'h0000_3004);
    check("reset_misalign", {31'b0, w_misalign}, 32'h0);

    // First load after release
    rst   = 1'b0;
    w_npc = 32'h0000_2000;
    step();
    check("first_load", w_pc, 32'h0000_2000);

    // NPC change between edges must not move PC
    #3 w_npc = 32'h0000_5000;
    #1;
    check("npc_midcycle_hold", w_pc, 32'h0000_2000);
    step();
    check("npc_next_edge", w_pc, 32'h0000_5000);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("async_reset_pc",     w_pc,       32'h0000_3000);
    check("async_reset_plus4",  w_pc_plus4, 32'h0000_3004);
    w_npc = 32'h0001_0000;
    #1 rst = 1'b0;
    #1;
    check("release_no_load", w_pc, 32'h0000_3000);
    step();
    check("load_after_release", w_pc,       32'h0001_0000);
    check("plus4_seq0",         w_pc_plus4, 32'h0001_0004);

    w_npc = 32'h0001_0004;
    step();
    check("seq1_pc",    w_pc,       32'h0001_0004);
    check("seq1_plus4", w_pc_plus4, 32'h0001_0008);
    check("aligned_no_misalign", {31'b0, w_misalign}, 32'h0);

    // Wrap of the incrementer
    w_npc = 32'hFFFF_FFFC;
    step();
    check("wrap_pc",    w_pc,       32'hFFFF_FFFC);
    check("wrap_plus4", w_pc_plus4, 32'h0000_0000);

    // Misaligned load is taken unmodified; flag is sticky
    w_npc = 32'h0000_2002;
    step();
    check("misaligned_pc",    w_pc,       32'h0000_2002);
    check("misaligned_plus4", w_pc_plus4, 32'h0000_2006);
    check("misalign_set", {31'b0, w_misalign}, {31'b0, c_ALIGN_EN});

    w_npc = 32'h0000_2004;
    step();
    check("after_misalign_pc", w_pc, 32'h0000_2004);
    check("misalign_sticky", {31'b0, w_misalign}, {31'b0, c_ALIGN_EN});

    #2 rst = 1'b1;
    #1;
    check("misalign_cleared", {31'b0, w_misalign}, 32'h0);
    check("final_reset_pc",   w_pc, 32'h0000_3000);
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", r_passed, r_checks);
    $finish;
  end

endmodule : tb_program_counter

`default_nettype wire

// File: doc/program_counter.md
# program_counter

Program counter register for the single-cycle CPU datapath. It holds the address of the instruction being fetched and loads the next-PC value computed by the next-PC logic on every rising clock edge. It sits between the NPC mux and the instruction memory address port. It also supplies a precomputed sequential address and a misalignment flag to the surrounding logic.

## Interface
Parameters:
- WIDTH, 32: address width in bits.
- RESET_VECTOR, 32'h0000_3000: PC value while and after reset.

Ports, listed clock and reset first:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- NPC  in  WIDTH  next program counter, loaded on each rising edge.
- PC  out  WIDTH  current program counter; registered output.
- PC_PLUS4  out  WIDTH  PC + 4, combinational from PC.
- MISALIGN  out  1  sticky flag; set when a loaded NPC has bits [1:0] != 0.

Positional declaration order is fixed as PC, CLOCK, RESET, NPC, PC_PLUS4, MISALIGN. Existing four-port positional instantiations must stay valid.

## Operation
- RESET high: PC = RESET_VECTOR and MISALIGN = 0, immediately and independent of CLOCK.
- RESET low, rising CLOCK edge: PC <= NPC. There is no enable and no stall; a load happens every cycle.
- NPC is loaded unmodified, with no alignment masking.
- If NPC[1:0] != 0 at a load edge, MISALIGN <= 1. MISALIGN is cleared only by RESET.
- PC_PLUS4 = PC + 4, modulo 2^WIDTH. It wraps: 32'hFFFF_FFFC gives 32'h0000_0000.
- Outputs carry no X after reset, even if NPC is X before the first edge.

## Timing
- Latency: NPC appears on PC one edge after it is sampled, with zero additional cycles.
- Reset assertion takes effect asynchronously, mid-cycle.
- Reset release takes effect synchronously. The first load happens on the first rising edge where RESET is already low.
- RESET rising and CLOCK rising edge at the same instant: reset wins, and PC = RESET_VECTOR.
- NPC changing between edges has no effect on PC.
- PC_PLUS4 settles combinationally within the same cycle as PC.

## Configuration
- PC_ALIGN_CHECK_EN defined: MISALIGN behaves as described above. In simulation, each misaligned load also prints an error line with time, NPC and the previous PC.
- PC_ALIGN_CHECK_EN undefined: MISALIGN is tied to 0, and no check logic or messages are generated.
- The port list is identical in both builds.

## Structure
- The shared package cpu_pkg holds these items:
  - ADDR_W = 32.
  - RESET_VECTOR default 32'h0000_3000.
  - INSTR_BYTES = 4.
  - typedef addr_t.
- A single module with no sub-modules. The PC + 4 incrementer is inline; a separate adder instance is not warranted.

## Test plan
- Hold RESET = 1 with NPC = 32'h0000_0000 across two edges -> PC = 32'h0000_3000, PC_PLUS4 = 32'h0000_3004, MISALIGN = 0.
- Release RESET, NPC = 32'h0000_2000 -> PC = 32'h0000_2000 after the next rising edge. Changing NPC mid-cycle leaves PC unchanged until the following edge.
- PC = 32'h0000_2000, assert RESET mid-cycle, away from any edge -> PC = 32'h0000_3000 immediately. RESET is released while NPC = 32'h0001_0000 -> PC = 32'h0001_0000 at the first edge after release.
- Sequential NPC values 32'h0001_0000 and 32'h0001_0004 on consecutive edges -> PC follows one per cycle, and PC_PLUS4 is always PC + 4.
- NPC = 32'hFFFF_FFFC -> PC = 32'hFFFF_FFFC and PC_PLUS4 = 32'h0000_0000.
- With PC_ALIGN_CHECK_EN: NPC = 32'h0000_2002 -> MISALIGN = 1 after the edge and stays 1 after NPC = 32'h0000_2004 loads, then clears on RESET. Without the macro -> MISALIGN remains 0.
